// File: rtl/grey4_decode_chk_pkg.sv
// Shared types and helpers for the 4-bit Gray decoder / sequence checker.
package grey4_decode_chk_pkg;

    // FSM encoding is fixed so the state can be observed and compared directly.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Classification of a new sample against the previous decoded value.
    typedef enum logic [1:0] {
        STEP_GOOD = 2'd0,
        STEP_HOLD = 2'd1,
        STEP_BAD  = 2'd2
    } step_t;

    // Gray to binary: b3 = g3, bi = b(i+1) ^ gi.
    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/grey4_decode_chk_to_bin.sv
// Combinational 4-bit Gray to binary converter.
module grey4_to_bin
    import grey4_decode_chk_pkg::*;
(
    input  logic [3:0] i_gray,
    output logic [3:0] o_bin
);

    assign o_bin = gray2bin(i_gray);

endmodule

// File: rtl/grey4_decode_chk.sv
// Gray count decoder with +1 sequence checking, lock tracking and a
// saturating error counter.
module grey4_decode_chk
    import grey4_decode_chk_pkg::*;
#(
    parameter int LOCK_N = 2,
    parameter int ERRW   = 8
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            ce,
    input  logic [3:0]      G,
    output logic [3:0]      B,
    output logic            VALID,
    output logic            LOCK,
    output logic            ERR,
    output logic [ERRW-1:0] ERRCNT,
    output logic            TC,
    output logic            CEO
);

    localparam logic [3:0] LOCK_GOOD = 4'(LOCK_N);

    state_t          r_state;
    logic [3:0]      r_good;
    logic [3:0]      r_b;
    logic            r_valid;
    logic            r_err;
    logic [ERRW-1:0] r_errcnt;
    logic            r_tc;

    logic [3:0]      w_bin;
    step_t           w_step;
    state_t          w_state_nx;
    logic [3:0]      w_good_nx;
    logic            w_err_nx;
    logic [ERRW-1:0] w_errcnt_nx;
    logic            w_lock_nx;

    grey4_to_bin u_to_bin (
        .i_gray (G),
        .o_bin  (w_bin)
    );

    // Classify the incoming sample against the last registered value (wrap 15->0 is a +1).
    always_comb begin
        if (w_bin == r_b + 4'd1) begin
            w_step = STEP_GOOD;
        end else if (w_bin == r_b) begin
            w_step = STEP_HOLD;
        end else begin
            w_step = STEP_BAD;
        end
    end

    // Next-state logic; only consumed on a sampling edge.
    always_comb begin
        w_state_nx  = r_state;
        w_good_nx   = r_good;
        w_err_nx    = 1'b0;
        w_errcnt_nx = r_errcnt;
        case (r_state)
            ST_IDLE: begin
                // First sample only seeds the reference value.
                w_state_nx = ST_TRACK;
                w_good_nx  = '0;
            end
            ST_TRACK: begin
                case (w_step)
                    STEP_GOOD: begin
                        w_good_nx = r_good + 4'd1;
                        if (w_good_nx >= LOCK_GOOD) begin
                            w_state_nx = ST_LOCKED;
                        end
                    end
                    STEP_HOLD: w_good_nx = r_good;
                    default:   w_good_nx = '0;
                endcase
            end
            ST_LOCKED: begin
                if (w_step == STEP_BAD) begin
                    w_err_nx   = 1'b1;
                    w_state_nx = ST_TRACK;
                    w_good_nx  = '0;
                    if (r_errcnt != {ERRW{1'b1}}) begin
                        w_errcnt_nx = r_errcnt + ERRW'(1);
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_good_nx  = '0;
            end
        endcase
    end

    assign w_lock_nx = (w_state_nx == ST_LOCKED);

    // All state: clr wins, ce samples, otherwise hold and drop the pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= ST_IDLE;
            r_good   <= '0;
            r_b      <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_errcnt <= '0;
            r_tc     <= 1'b0;
        end else if (ce) begin
            r_state  <= w_state_nx;
            r_good   <= w_good_nx;
            r_b      <= w_bin;
            r_valid  <= 1'b1;
            r_err    <= w_err_nx;
            r_errcnt <= w_errcnt_nx;
            r_tc     <= w_lock_nx && (w_bin == 4'hF);
        end else begin
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end
    end

    assign B      = r_b;
    assign VALID  = r_valid;
    assign LOCK   = (r_state == ST_LOCKED);
    assign ERR    = r_err;
    assign ERRCNT = r_errcnt;
    assign TC     = r_tc;
    assign CEO    = ce & r_tc;

endmodule

// File: tb/tb_grey4_decode_chk.sv
// Randomized bench for grey4_decode_chk against a behavioural model.
module tb_grey4_decode_chk;

    logic       gclk = 1'b0;
    logic       clr  = 1'b1;
    logic       ce   = 1'b0;
    logic [3:0] G    = 4'h0;

    logic [3:0] B, B2;
    logic       VALID, LOCK, ERR, TC, CEO;
    logic       VALID2, LOCK2, ERR2, TC2, CEO2;
    logic [7:0] ERRCNT;
    logic [1:0] ERRCNT2;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural model state.
    int m_b, m_good, m_err8, m_err2;
    bit m_start, m_lock, m_valid, m_err, m_tc;

    always #5 gclk = ~gclk;

    grey4_decode_chk #(.LOCK_N(2), .ERRW(8)) dut (
        .clk(gclk), .clr(clr), .ce(ce), .G(G),
        .B(B), .VALID(VALID), .LOCK(LOCK), .ERR(ERR),
        .ERRCNT(ERRCNT), .TC(TC), .CEO(CEO)
    );

    grey4_decode_chk #(.LOCK_N(2), .ERRW(2)) dut2 (
        .clk(gclk), .clr(clr), .ce(ce), .G(G),
        .B(B2), .VALID(VALID2), .LOCK(LOCK2), .ERR(ERR2),
        .ERRCNT(ERRCNT2), .TC(TC2), .CEO(CEO2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [3:0] gray(input int b);
        logic [3:0] v;
        v = 4'(b & 15);
        return v ^ (v >> 1);
    endfunction

    // Decode by searching the encoder, independent of the XOR chain.
    function automatic int ungray(input logic [3:0] g);
        for (int k = 0; k < 16; k++) if (gray(k) == g) return k;
        return 0;
    endfunction

    task automatic model_edge();
        int nb, d;
        if (clr) begin
            m_b = 0; m_good = 0; m_err8 = 0; m_err2 = 0;
            m_start = 0; m_lock = 0; m_valid = 0; m_err = 0; m_tc = 0;
        end else if (ce) begin
            nb = ungray(G);
            m_valid = 1;
            m_err = 0;
            if (!m_start) begin
                m_start = 1;
                m_good = 0;
            end else begin
                d = (nb - m_b + 16) % 16;
                if (m_lock) begin
                    if (d > 1) begin
                        m_err = 1;
                        m_lock = 0;
                        m_good = 0;
                        if (m_err8 < 255) m_err8++;
                        if (m_err2 < 3) m_err2++;
                    end
                end else begin
                    if (d == 1) m_good++;
                    else if (d != 0) m_good = 0;
                    if (m_good >= 2) m_lock = 1;
                end
            end
            m_b = nb;
            m_tc = m_lock && (nb == 15);
        end else begin
            m_valid = 0;
            m_err = 0;
        end
    endtask

    task automatic step(input bit c, input bit r, input logic [3:0] g);
        ce = c; clr = r; G = g;
        @(posedge gclk);
        model_edge();
        #1;
        chk("B", 32'(B), 32'(m_b));
        chk("VALID", 32'(VALID), 32'(m_valid));
        chk("LOCK", 32'(LOCK), 32'(m_lock));
        chk("ERR", 32'(ERR), 32'(m_err));
        chk("ERRCNT", 32'(ERRCNT), 32'(m_err8));
        chk("TC", 32'(TC), 32'(m_tc));
        chk("CEO", 32'(CEO), 32'(ce & m_tc));
        chk("ERRCNT_w2", 32'(ERRCNT2), 32'(m_err2));
    endtask

    task automatic lock_at(input int b);
        step(1, 0, gray(b - 2));
        step(1, 0, gray(b - 1));
        step(1, 0, gray(b));
    endtask

    initial begin
        logic [3:0] sv_b;
        logic [7:0] sv_cnt;
        logic       sv_lock;
        int         pick;

        // Reset state, with ce high to show clr wins.
        step(1, 1, 4'h7);
        step(0, 1, 4'h0);
        chk("rst_B", 32'(B), 32'd0);
        chk("rst_LOCK", 32'(LOCK), 32'd0);

        // Full sweep 0..15,0..3.
        for (int i = 0; i < 20; i++) begin
            step(1, 0, gray(i));
            if (i == 1) chk("sweep_nolock", 32'(LOCK), 32'd0);
            if (i == 2) chk("sweep_lock", 32'(LOCK), 32'd1);
        end

        // Hold at 5.
        step(1, 0, gray(4));
        step(1, 0, gray(5));
        step(1, 0, gray(5));
        step(1, 0, gray(5));
        chk("hold_B", 32'(B), 32'd5);
        chk("hold_LOCK", 32'(LOCK), 32'd1);
        chk("hold_ERRCNT", 32'(ERRCNT), 32'd0);

        // Skip 6 -> 8.
        step(1, 0, gray(6));
        step(1, 0, gray(8));
        chk("skip_ERR", 32'(ERR), 32'd1);
        chk("skip_ERRCNT", 32'(ERRCNT), 32'd1);
        chk("skip_LOCK", 32'(LOCK), 32'd0);
        chk("skip_B", 32'(B), 32'd8);
        step(1, 0, gray(9));
        chk("skip_ERR_once", 32'(ERR), 32'd0);
        step(1, 0, gray(10));
        chk("relock", 32'(LOCK), 32'd1);

        // Two more errors, ending locked at 9 with ERRCNT=3, then clr.
        lock_at(4);
        lock_at(9);
        chk("pre_clr_cnt", 32'(ERRCNT), 32'd3);
        chk("pre_clr_B", 32'(B), 32'd9);
        step(1, 1, gray(10));
        chk("clr_B", 32'(B), 32'd0);
        chk("clr_cnt", 32'(ERRCNT), 32'd0);
        chk("clr_LOCK", 32'(LOCK), 32'd0);
        step(1, 0, gray(2));
        chk("clr_first_noerr", 32'(ERR), 32'd0);
        chk("clr_first_track", 32'(dut.r_state), 32'd1);

        // Saturation on the narrow counter.
        lock_at(12);
        for (int i = 0; i < 5; i++) lock_at((i % 2 == 0) ? 4 : 12);
        chk("sat_w2", 32'(ERRCNT2), 32'd3);
        chk("sat_w8", 32'(ERRCNT), 32'd5);

        // ce gating with random G.
        sv_b = B; sv_cnt = ERRCNT; sv_lock = LOCK;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 4'($urandom));
            chk("gate_B", 32'(B), 32'(sv_b));
            chk("gate_cnt", 32'(ERRCNT), 32'(sv_cnt));
            chk("gate_LOCK", 32'(LOCK), 32'(sv_lock));
            chk("gate_VALID", 32'(VALID), 32'd0);
        end

        // Random traffic biased toward legal counting.
        for (int i = 0; i < 400; i++) begin
            pick = $urandom_range(0, 99);
            if (pick < 2)       step(1, 1, 4'($urandom));
            else if (pick < 15) step(0, 0, 4'($urandom));
            else if (pick < 70) step(1, 0, gray(m_b + 1));
            else if (pick < 82) step(1, 0, gray(m_b));
            else                step(1, 0, 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
